imm_extend_unit: RTL

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

---
 rtl/imm_extend_unit_if.sv | 22 ++
 rtl/imm_extend_unit.sv | 57 +++++
 2 files changed

// File: rtl/imm_extend_unit_if.sv
// imm_extend_unit_if: producer/consumer handshake bundle around the immediate extender
interface imm_extend_unit_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [IN_W-1:0]  in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_ovf;
  modport master (
    output in_valid, in_mode, in_imm, out_ready,
    input  in_ready, out_valid, out_imm, out_ovf
  );
  modport slave (
    input  in_valid, in_mode, in_imm, out_ready,
    output in_ready, out_valid, out_imm, out_ovf
  );
endinterface

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: immediate zero/sign/upper/branch extension into a 2-entry skid FIFO
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input logic clk,
  input logic rst,
  imm_extend_unit_if.slave bus
);
  localparam int EXT_W = OUT_W - IN_W;
  localparam logic [1:0] M_ZERO  = 2'd0;
  localparam logic [1:0] M_SIGN  = 2'd1;
  localparam logic [1:0] M_UPPER = 2'd2;
  generate
    if (OUT_W < IN_W + 2 || IN_W < 2) begin : g_bad_params
      $error("imm_extend_unit: requires IN_W >= 2 and OUT_W >= IN_W + 2");
    end
  endgenerate
  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] ext;
  logic             ovf;
  logic [OUT_W:0]   mem [2];
  logic             wp;
  logic             rp;
  logic [1:0]       cnt;
  logic             wr;
  logic             rd;
  assign sx = {{EXT_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
  always_comb begin
    ext = bus.in_mode == M_ZERO  ? {{EXT_W{1'b0}}, bus.in_imm} :
          bus.in_mode == M_SIGN  ? sx :
          bus.in_mode == M_UPPER ? {bus.in_imm, {EXT_W{1'b0}}} :
                                   {sx[OUT_W-3:0], 2'b00};
    // unreachable with legal widths, kept as a guard on the branch shift
    ovf = bus.in_mode == 2'd3 && (sx[OUT_W-1:OUT_W-2] != {2{sx[OUT_W-3]}});
  end
  assign wr = bus.in_valid && bus.in_ready;
  assign rd = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (wr) mem[wp] <= {ext, ovf};
      wp  <= wp ^ wr;
      rp  <= rp ^ rd;
      cnt <= cnt + {1'b0, wr} - {1'b0, rd};
    end
  end
  assign bus.in_ready  = cnt != 2'd2;
  assign bus.out_valid = cnt != 2'd0;
  // when empty, the slot behind rp is the last word read and has not been rewritten
  assign {bus.out_imm, bus.out_ovf} = mem[bus.out_valid ? rp : ~rp];
endmodule
